ets_delay_sweeper: RTL and testbench
====================================

Name: ets_delay_sweeper

Overview:
Sequencer that drives the 8-bit `delay` input of the ETS phase-offset clock generator across a programmed sweep. For each phase step it applies the delay, waits for the generator to settle, then handshakes with the offset sampler to capture one acquisition. It sits between the acquisition control logic and ets_clkgen, and produces the phase index that tags captured samples.

Parameters:
DELAY_START, 0, first delay code applied (0-255).
DELAY_STEP, 1, delay code increment per step (1-255); 8-bit add, wraps modulo 256.
NUM_STEPS, 256, steps per sweep (1-256).
SETTLE_CYCLES, 16, clk cycles the delay is held before a capture request (>=1).
TIMEOUT_CYCLES, 1024, max cycles capture_req waits for capture_ack (>=2).

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse; begins a sweep when idle.
abort  in  1  level; cancels the sweep in progress.
capture_ack  in  1  sampler has completed the capture for the current step.
capture_req  out  1  request one capture at the current delay.
delay  out  8  delay code to ets_clkgen.
step_index  out  8  zero-based index of the current step.
busy  out  1  high while a sweep is in progress.
done  out  1  one-cycle pulse when a sweep completes normally.
timeout_err  out  1  sticky; the sampler failed to ack in time.

Behaviour:
- Reset values: capture_req=0, delay=DELAY_START, step_index=0, busy=0, done=0, timeout_err=0, state=IDLE, counters=0.
- States: IDLE, SETTLE, CAPTURE, DONE. All outputs are registered.
- IDLE:
  - When start=1 and abort=0: next cycle delay=DELAY_START, step_index=0, settle counter loaded, busy=1, timeout_err cleared, state -> SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles with delay stable, then -> CAPTURE.
  - capture_req rises on the first CAPTURE cycle.
- CAPTURE:
  - capture_req is held high until capture_ack is sampled high.
  - On the ack cycle, if step_index==NUM_STEPS-1: capture_req drops, state -> DONE.
  - Otherwise, in that same edge: capture_req drops, delay<=delay+DELAY_STEP (8-bit wrap), step_index++, settle counter reloads, state -> SETTLE.
  - The gap between successive capture_req rises is therefore SETTLE_CYCLES+1 cycles after the ack.
- Timeout: a counter clears on entry to CAPTURE. If TIMEOUT_CYCLES cycles elapse with no ack, set timeout_err=1, capture_req=0, busy=0, state -> IDLE. No done pulse is issued.
- DONE: done=1 for exactly one cycle, busy=0, state -> IDLE. delay and step_index hold their final values.
- abort=1 in any non-IDLE state: next cycle state=IDLE, capture_req=0, busy=0, no done. delay and step_index hold.
- abort and start asserted together in IDLE: abort wins and no sweep starts.
- start while busy is ignored. capture_ack outside CAPTURE is ignored.
- capture_ack held high across steps: each CAPTURE state consumes at most one ack.
- Reset mid-sweep: all outputs go immediately to their reset values; no done pulse.

Optional Feature:
Macro ETS_LOCK_WAIT_EN.
- Defined:
  - Adds input port clkgen_locked (1 bit).
  - SETTLE exits only when the settle count has expired AND clkgen_locked=1; SETTLE holds indefinitely while it is low.
  - abort still applies during the hold.
- Undefined: the port is absent and SETTLE is purely count-based.

Test Plan:
1. Defaults; start pulse; ack 3 cycles after each req -> delay 0,1,...,255 and step_index 0..255. Exactly 16 cycles between delay change and req rise. One done pulse after the 256th ack; busy then 0.
2. DELAY_START=250, DELAY_STEP=3, NUM_STEPS=4 -> delay sequence 250, 253, 0, 3. done after the 4th ack; delay stays 3.
3. Never ack, TIMEOUT_CYCLES=8 -> req high 8 cycles then drops. timeout_err=1, busy=0, no done. Next start clears timeout_err.
4. abort during the 3rd CAPTURE -> req=0 and busy=0 next cycle, step_index stays 2, no done. Simultaneous start+abort in IDLE -> stays idle.
5. capture_ack tied high -> one step per SETTLE_CYCLES+1 cycles, each req high exactly 1 cycle. start pulses mid-sweep have no effect.
6. ETS_LOCK_WAIT_EN defined, clkgen_locked low for 40 cycles at step 0 -> req rises only after lock goes high (and not before 16 cycles). Assert reset_n low mid-wait -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ets_delay_sweeper.sv
// Purpose: steps the ets_clkgen delay code through a programmed sweep, one capture per step.
// Latency: SETTLE_CYCLES cycles from each delay change to capture_req; DONE one cycle after the last ack.
// Backpressure: capture_req is held until capture_ack or TIMEOUT_CYCLES, then aborts with timeout_err.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   start               one-cycle pulse, starts a sweep when idle
//   abort               level, cancels the sweep in progress (wins over start)
//   capture_ack         sampler finished the capture for the current step
//   clkgen_locked       (only with ETS_LOCK_WAIT_EN) generator has settled on the new delay
//   capture_req         request one capture at the current delay
//   delay, step_index   delay code to ets_clkgen and zero-based step tag
//   busy, done          sweep in progress / one-cycle completion pulse
//   timeout_err         sticky, sampler did not ack in time; cleared by the next start
//
// Optional feature macro: ETS_LOCK_WAIT_EN (adds clkgen_locked and gates SETTLE exit on it).
module ets_delay_sweeper #(
    parameter int DELAY_START    = 0,
    parameter int DELAY_STEP     = 1,
    parameter int NUM_STEPS      = 256,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       capture_ack,
`ifdef ETS_LOCK_WAIT_EN
    input  logic       clkgen_locked,
`endif
    output logic       capture_req,
    output logic [7:0] delay,
    output logic [7:0] step_index,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    // Counters hold "cycles remaining - 1" (settle) and "cycles elapsed" (timeout),
    // so their widths only need to cover N-1.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LAST_STEP   = 8'(NUM_STEPS - 1);
    localparam logic [7:0]    D_START     = 8'(DELAY_START);
    localparam logic [7:0]    D_STEP      = 8'(DELAY_STEP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] to_cnt;
    logic          lock_ok;

`ifdef ETS_LOCK_WAIT_EN
    assign lock_ok = clkgen_locked;
`else
    assign lock_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            capture_req <= 1'b0;
            delay       <= D_START;
            step_index  <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // done is high only during the single DONE-state cycle
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        delay       <= D_START;
                        step_index  <= 8'd0;
                        settle_cnt  <= SETTLE_LOAD;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        state       <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt == '0) begin
                        // count has expired; wait here (count frozen) until the generator is locked
                        if (lock_ok) begin
                            capture_req <= 1'b1;
                            to_cnt      <= '0;
                            state       <= CAPTURE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                CAPTURE: begin
                    if (abort) begin
                        capture_req <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (capture_ack) begin
                        // leaving CAPTURE here guarantees a held-high ack is used once per step
                        capture_req <= 1'b0;
                        if (step_index == LAST_STEP) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            delay      <= delay + D_STEP;
                            step_index <= step_index + 8'd1;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // TIMEOUT_CYCLES capture cycles have passed without an ack
                        capture_req <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    capture_req <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ets_delay_sweeper.sv
// Bench for ets_delay_sweeper: instance 0 uses default parameters, instance 1 a short
// wrapping sweep (start 250, step 3, 4 steps, settle 5, timeout 8).
module tb_ets_delay_sweeper;

    logic            clk;
    logic            reset_n;
    logic [1:0]      start;
    logic [1:0]      abort;
    logic [1:0]      ack;
    logic [1:0]      req;
    logic [1:0][7:0] delay;
    logic [1:0][7:0] step_index;
    logic [1:0]      busy;
    logic [1:0]      done;
    logic [1:0]      terr;
`ifdef ETS_LOCK_WAIT_EN
    logic            clkgen_locked;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];   // {expected delay, expected step_index} per capture request

    ets_delay_sweeper u_def (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start[0]),
        .abort       (abort[0]),
        .capture_ack (ack[0]),
`ifdef ETS_LOCK_WAIT_EN
        .clkgen_locked (clkgen_locked),
`endif
        .capture_req (req[0]),
        .delay       (delay[0]),
        .step_index  (step_index[0]),
        .busy        (busy[0]),
        .done        (done[0]),
        .timeout_err (terr[0])
    );

    ets_delay_sweeper #(
        .DELAY_START    (250),
        .DELAY_STEP     (3),
        .NUM_STEPS      (4),
        .SETTLE_CYCLES  (5),
        .TIMEOUT_CYCLES (8)
    ) u_short (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start[1]),
        .abort       (abort[1]),
        .capture_ack (ack[1]),
`ifdef ETS_LOCK_WAIT_EN
        .clkgen_locked (clkgen_locked),
`endif
        .capture_req (req[1]),
        .delay       (delay[1]),
        .step_index  (step_index[1]),
        .busy        (busy[1]),
        .done        (done[1]),
        .timeout_err (terr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count clock edges until capture_req is seen high (bounded).
    task automatic wait_req(input int d, output int n);
        n = 0;
        while (req[d] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Full sweep with ack returned ack_lat cycles after each request rise.
    task automatic run_sweep(input int d, input int s, input int nsteps, input int d0,
                             input int dstep, input int ack_lat);
        logic [7:0]  ed;
        logic [7:0]  last_d;
        logic [15:0] e;
        int          n;
        ed = d0[7:0];
        last_d = ed;
        for (int i = 0; i < nsteps; i++) begin
            exp_q.push_back({ed, 8'(i)});
            last_d = ed;
            ed = ed + dstep[7:0];
        end
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        chk("busy_after_start", busy[d], 1);
        for (int i = 0; i < nsteps; i++) begin
            wait_req(d, n);
            chk("settle_len", n, s);
            e = exp_q.pop_front();
            chk("delay_at_req", delay[d], e[15:8]);
            chk("step_at_req", step_index[d], e[7:0]);
            repeat (ack_lat - 1) tick();
            chk("req_held", req[d], 1);
            ack[d] = 1'b1;
            tick();
            ack[d] = 1'b0;
            chk("req_drop_on_ack", req[d], 0);
        end
        chk("done_pulse", done[d], 1);
        chk("busy_at_done", busy[d], 0);
        tick();
        chk("done_one_cycle", done[d], 0);
        chk("final_delay", delay[d], last_d);
        chk("final_step", step_index[d], nsteps - 1);
    endtask

    initial begin
        int          n;
        int          hi;
        logic [15:0] e;

        reset_n = 1'b0;
        start   = '0;
        abort   = '0;
        ack     = '0;
`ifdef ETS_LOCK_WAIT_EN
        clkgen_locked = 1'b1;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_req", req, 0);
        chk("rst_delay0", delay[0], 0);
        chk("rst_delay1", delay[1], 250);
        chk("rst_step", step_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_terr", terr, 0);

        // Full default sweep, ack 3 cycles after each request
        run_sweep(0, 16, 256, 0, 1, 3);

        // Short wrapping sweep: 250, 253, 0, 3
        run_sweep(1, 5, 4, 250, 3, 3);

        // Timeout: never ack
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        wait_req(1, n);
        chk("to_settle_len", n, 5);
        n = 0;
        while (req[1] === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("to_req_width", n, 8);
        chk("to_terr", terr[1], 1);
        chk("to_busy", busy[1], 0);
        chk("to_no_done", done[1], 0);
        tick();
        chk("to_terr_sticky", terr[1], 1);

        // Next start clears timeout_err; abort during the 3rd capture
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        chk("restart_terr_clr", terr[1], 0);
        chk("restart_busy", busy[1], 1);
        for (int i = 0; i < 2; i++) begin
            wait_req(1, n);
            chk("ab_settle_len", n, 5);
            ack[1] = 1'b1;
            tick();
            ack[1] = 1'b0;
        end
        wait_req(1, n);
        chk("ab_step_at_req", step_index[1], 2);
        tick();
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        chk("ab_req", req[1], 0);
        chk("ab_busy", busy[1], 0);
        chk("ab_done", done[1], 0);
        chk("ab_step_hold", step_index[1], 2);
        chk("ab_delay_hold", delay[1], 0);
        start[1] = 1'b1;
        abort[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        abort[1] = 1'b0;
        chk("start_abort_busy", busy[1], 0);
        repeat (10) tick();
        chk("start_abort_req", req[1], 0);
        chk("start_abort_step", step_index[1], 2);

        // ack tied high: one step per 17 cycles, 1-cycle requests, start ignored mid-sweep
        ack[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 0; k < 6; k++) exp_q.push_back({8'(k), 8'(k)});
        for (int k = 0; k < 6; k++) begin
            wait_req(0, n);
            chk("tied_gap", n, 16);
            e = exp_q.pop_front();
            chk("tied_delay", delay[0], e[15:8]);
            chk("tied_step", step_index[0], e[7:0]);
            tick();
            chk("tied_req_width", req[0], 0);
            start[0] = (k % 2 == 1);
        end
        start[0] = 1'b0;
        chk("tied_busy", busy[0], 1);

        // Reset mid-sweep: outputs at reset values immediately
        reset_n = 1'b0;
        #2;
        chk("mid_rst_req", req[0], 0);
        chk("mid_rst_delay", delay[0], 0);
        chk("mid_rst_step", step_index[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_done", done[0], 0);
        ack[0] = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

`ifdef ETS_LOCK_WAIT_EN
        // Lock wait: SETTLE holds while clkgen_locked is low
        clkgen_locked = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        hi = 0;
        repeat (40) begin
            if (req[0] !== 1'b0) hi++;
            tick();
        end
        chk("lock_no_req", hi, 0);
        chk("lock_busy", busy[0], 1);
        clkgen_locked = 1'b1;
        tick();
        chk("lock_req_rise", req[0], 1);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        clkgen_locked = 1'b0;
        repeat (30) tick();
        chk("lock_hold_req", req[0], 0);
        chk("lock_hold_delay", delay[0], 1);
        reset_n = 1'b0;
        #2;
        chk("lock_rst_delay", delay[0], 0);
        chk("lock_rst_step", step_index[0], 0);
        chk("lock_rst_busy", busy[0], 0);
        chk("lock_rst_req", req[0], 0);
        tick();
        reset_n = 1'b1;
        clkgen_locked = 1'b1;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
